// File: rtl/fridge_setting_reader.sv
// fridge_setting_reader
// Read-back path for the fridge controller's stored settings. A read request
// selects one 5-bit setting, which is snapshotted into rd_data and sent LSB
// first as an asynchronous serial frame on tx_out:
// start(0), 5 data bits, [even parity], STOP_BITS stop bits (1).
// Compile-time option: define FRIDGE_READER_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bits.
// Legal parameter ranges: CLKS_PER_BIT 1..1023, STOP_BITS 1 or 2.
module fridge_setting_reader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr,
  input  logic       rd_req,
  input  logic       rd_s0,
  input  logic       rd_s1,
  input  logic       rd_s2,
  input  logic [4:0] fgt,
  input  logic [4:0] frt,
  input  logic [4:0] fgc,
  input  logic [4:0] frc,
  input  logic       fgp,
  input  logic       frp,
  output logic [4:0] rd_data,
  output logic       rd_busy,
  output logic       rd_done,
  output logic       rd_err,
  output logic       tx_out
);

  // The timer must hold up to 2 * 1023 - 1 for the longest stop period.
  localparam int TW = 11;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FRIDGE_READER_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [4:0]      data_reg, data_next;
  logic [4:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  logic [1:0]      sel;
  logic            sel_valid;
  logic [4:0]      sel_value;

  assign sel = {rd_s0, rd_s1};

  // Decode the selector into the setting that would be snapshotted.
  always_comb begin
    sel_valid = 1'b1;
    sel_value = 5'd0;
    case (sel)
      2'b00:   sel_value = rd_s2 ? frt : fgt;
      2'b01:   sel_value = rd_s2 ? frc : fgc;
      2'b10:   sel_value = {4'b0000, (rd_s2 ? frp : fgp)};
      default: sel_valid = 1'b0;
    endcase
  end

  // State, bit timer, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= 3'd0;
      data_reg    <= 5'd0;
      shift_reg   <= 5'd0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      data_reg    <= data_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  // Next-state and datapath: accept/reject requests, time each bit, abort on power loss.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_idx_next = bit_idx_reg;
    data_next    = data_reg;
    shift_next   = shift_reg;
    err_next     = 1'b0;

    if (busy_reg && !pwr) begin
      // Power lost mid-frame: drop the frame, keep the snapshot, flag it.
      state_next   = IDLE;
      timer_next   = '0;
      bit_idx_next = 3'd0;
      err_next     = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rd_req && pwr) begin
            if (sel_valid) begin
              data_next    = sel_value;
              shift_next   = sel_value;
              bit_idx_next = 3'd0;
              timer_next   = BIT_LAST;
              state_next   = START;
            end else begin
              err_next = 1'b1;
            end
          end
        end

        START: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - 1'b1;
          end else begin
            timer_next   = BIT_LAST;
            bit_idx_next = 3'd0;
            state_next   = DATA;
          end
        end

        DATA: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - 1'b1;
          end else if (bit_idx_reg == 3'd4) begin
`ifdef FRIDGE_READER_PARITY_EN
            timer_next = BIT_LAST;
            state_next = PARITY;
`else
            timer_next = STOP_LAST;
            state_next = STOP;
`endif
          end else begin
            timer_next   = BIT_LAST;
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[4:1]};
          end
        end

`ifdef FRIDGE_READER_PARITY_EN
        PARITY: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - 1'b1;
          end else begin
            timer_next = STOP_LAST;
            state_next = STOP;
          end
        end
`endif

        STOP: begin
          if (timer_reg != '0) begin
            timer_next = timer_reg - 1'b1;
          end else begin
            timer_next = '0;
            state_next = DONE;
          end
        end

        DONE: begin
          // Requests are ignored here; the next one is taken from IDLE.
          state_next = IDLE;
        end

        default: begin
          state_next   = IDLE;
          timer_next   = '0;
          bit_idx_next = 3'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the line and flags come out of flops.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      START: begin
        tx_next   = 1'b0;
        busy_next = 1'b1;
      end
      DATA: begin
        tx_next   = shift_next[0];
        busy_next = 1'b1;
      end
`ifdef FRIDGE_READER_PARITY_EN
      PARITY: begin
        tx_next   = ^data_next;
        busy_next = 1'b1;
      end
`endif
      STOP: begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
      end
      DONE: begin
        done_next = 1'b1;
      end
      default: begin
        tx_next = 1'b1;
      end
    endcase
  end

  assign rd_data = data_reg;
  assign rd_busy = busy_reg;
  assign rd_done = done_reg;
  assign rd_err  = err_reg;
  assign tx_out  = tx_reg;

endmodule

// File: tb/tb_fridge_setting_reader.sv
// Self-checking bench for fridge_setting_reader. Expected frames are built
// from the frame rules (start bit, LSB-first data, optional parity, stop bits)
// by a cycle-indexed reference, with settings chosen randomly and directly.
module tb_fridge_setting_reader;

  localparam int CLKS = 4;
`ifdef FRIDGE_READER_PARITY_EN
  localparam int PAR   = 1;
  localparam int STOPB = 2;
`else
  localparam int PAR   = 0;
  localparam int STOPB = 1;
`endif
  localparam int FRAME = (1 + 5 + PAR + STOPB) * CLKS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwr;
  logic       rd_req;
  logic       rd_s0, rd_s1, rd_s2;
  logic [4:0] fgt, frt, fgc, frc;
  logic       fgp, frp;
  logic [4:0] rd_data;
  logic       rd_busy, rd_done, rd_err, tx_out;

  int checks = 0;
  int errors = 0;

  fridge_setting_reader #(
    .CLKS_PER_BIT(CLKS),
    .STOP_BITS   (STOPB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwr    (pwr),
    .rd_req (rd_req),
    .rd_s0  (rd_s0),
    .rd_s1  (rd_s1),
    .rd_s2  (rd_s2),
    .fgt    (fgt),
    .frt    (frt),
    .fgc    (fgc),
    .frc    (frc),
    .fgp    (fgp),
    .frp    (frp),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .rd_done(rd_done),
    .rd_err (rd_err),
    .tx_out (tx_out)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: which stored setting a selector names.
  function automatic logic [4:0] model_value(input logic [1:0] sel, input logic s2);
    case (sel)
      2'd0:    return s2 ? frt : fgt;
      2'd1:    return s2 ? frc : fgc;
      2'd2:    return {4'b0000, (s2 ? frp : fgp)};
      default: return 5'd0;
    endcase
  endfunction

  // Reference: line level at cycle c of a frame carrying d.
  function automatic logic model_tx(input int c, input logic [4:0] d);
    int b;
    b = c / CLKS;
    if (b == 0) return 1'b0;
    if (b <= 5) return d[b-1];
    if (PAR == 1 && b == 6) return ^d;
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check_bit({tag, " tx"},   tx_out,  1'b1);
    check_bit({tag, " busy"}, rd_busy, 1'b0);
    check_bit({tag, " done"}, rd_done, 1'b0);
  endtask

  task automatic send_req(input logic [1:0] sel, input logic s2);
    rd_s0  = sel[1];
    rd_s1  = sel[0];
    rd_s2  = s2;
    rd_req = 1'b1;
  endtask

  task automatic scramble_settings();
    fgt = 5'($urandom);
    frt = 5'($urandom);
    fgc = 5'($urandom);
    frc = 5'($urandom);
    fgp = 1'($urandom);
    frp = ~frp;
  endtask

  // Follow a whole frame cycle by cycle, from the first START cycle to DONE.
  task automatic run_frame(input logic [4:0] exp_d, input bit hold, input bit scramble,
                           input string tag);
    for (int c = 0; c <= FRAME; c++) begin
      @(negedge clk);
      if (!hold || c == FRAME) rd_req = 1'b0;
      if (scramble && c == 2 * CLKS + 1) scramble_settings();
      if (c < FRAME) begin
        check_bit($sformatf("%s tx c%0d", tag, c), tx_out, model_tx(c, exp_d));
        check_bit($sformatf("%s busy c%0d", tag, c), rd_busy, 1'b1);
        check_bit($sformatf("%s done c%0d", tag, c), rd_done, 1'b0);
      end else begin
        check_bit({tag, " done pulse"}, rd_done, 1'b1);
        check_bit({tag, " busy at done"}, rd_busy, 1'b0);
        check_bit({tag, " tx at done"}, tx_out, 1'b1);
      end
      check_bit($sformatf("%s err c%0d", tag, c), rd_err, 1'b0);
      check5($sformatf("%s data c%0d", tag, c), rd_data, exp_d);
    end
    repeat (3) begin
      @(negedge clk);
      check_idle({tag, " after"});
      check5({tag, " data after"}, rd_data, exp_d);
    end
    $display("frame %s: data=%b checks=%0d errors=%0d", tag, exp_d, checks, errors);
  endtask

  initial begin
    logic [1:0] sel;
    logic       s2;
    logic [4:0] exp_d;

    rst_n = 1'b0; pwr = 1'b0; rd_req = 1'b0;
    rd_s0 = 1'b0; rd_s1 = 1'b0; rd_s2 = 1'b0;
    fgt = 5'd0; frt = 5'd0; fgc = 5'd0; frc = 5'd0; fgp = 1'b0; frp = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_idle("reset");
    check_bit("reset err", rd_err, 1'b0);
    check5("reset data", rd_data, 5'd0);
    rst_n = 1'b1;
    $display("reset: checks=%0d errors=%0d", checks, errors);

    // Request with power off is ignored
    fgt = 5'b10110;
    send_req(2'b00, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rd_req = 1'b0;
      check_idle("pwr off");
      check_bit("pwr off err", rd_err, 1'b0);
      check5("pwr off data", rd_data, 5'd0);
    end
    $display("power-off request: checks=%0d errors=%0d", checks, errors);
    pwr = 1'b1;

    // Fridge temperature frame
    fgt = 5'b10110;
    send_req(2'b00, 1'b0);
    run_frame(5'b10110, 1'b0, 1'b0, "temp");

    // Freezer power flag; flag changes mid-frame
    frp = 1'b1;
    send_req(2'b10, 1'b1);
    run_frame(5'b00001, 1'b0, 1'b1, "power");

    // Invalid selector
    send_req(2'b11, 1'b0);
    @(negedge clk);
    rd_req = 1'b0;
    check_bit("inval err", rd_err, 1'b1);
    check_idle("inval");
    check5("inval data", rd_data, 5'b00001);
    @(negedge clk);
    check_bit("inval err end", rd_err, 1'b0);
    check_idle("inval later");
    $display("invalid selector: checks=%0d errors=%0d", checks, errors);

    // Abort by dropping power in data bit 2, request held high
    frc = 5'b00111;
    send_req(2'b01, 1'b1);
    for (int c = 0; c <= 3 * CLKS + 1; c++) begin
      @(negedge clk);
      check_bit($sformatf("abort tx c%0d", c), tx_out, model_tx(c, 5'b00111));
      check_bit($sformatf("abort busy c%0d", c), rd_busy, 1'b1);
    end
    pwr = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    pwr = 1'b1;
    check_bit("abort tx", tx_out, 1'b1);
    check_bit("abort busy", rd_busy, 1'b0);
    check_bit("abort err", rd_err, 1'b1);
    check_bit("abort done", rd_done, 1'b0);
    check5("abort data", rd_data, 5'b00111);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_idle("post abort");
      check_bit("post abort err", rd_err, 1'b0);
    end
    $display("abort: checks=%0d errors=%0d", checks, errors);

    // Request held high through a frame gives exactly one frame
    fgc = 5'b00111;
    send_req(2'b01, 1'b0);
    run_frame(5'b00111, 1'b1, 1'b0, "hold");

    // Random settings and selectors, settings disturbed mid-frame
    for (int n = 0; n < 6; n++) begin
      fgt = 5'($urandom); frt = 5'($urandom);
      fgc = 5'($urandom); frc = 5'($urandom);
      fgp = 1'($urandom); frp = 1'($urandom);
      sel = 2'($urandom_range(0, 2));
      s2  = 1'($urandom);
      exp_d = model_value(sel, s2);
      send_req(sel, s2);
      run_frame(exp_d, 1'($urandom), 1'b1, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a frame
    frt = 5'b01011;
    send_req(2'b00, 1'b1);
    repeat (5) @(negedge clk);
    rd_req = 1'b0;
    check_bit("pre-reset busy", rd_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    check_bit("midrst err", rd_err, 1'b0);
    check5("midrst data", rd_data, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("post midrst");
    end
    $display("mid-frame reset: checks=%0d errors=%0d", checks, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
